// File: rtl/cva6_wakeup_ctrl.sv
// Multi-hart reset-release and interrupt-conditioning controller for CVA6 tiles.
// Holds harts in reset for a wake-up period, releases them staggered, then serves soft resets.
module cva6_wakeup_ctrl #(
  parameter int unsigned NrHarts       = 2,
  parameter int unsigned NrIrq         = 2,
  parameter int unsigned SyncStages    = 2,
  parameter int unsigned WakeCycles    = 32768,
  parameter int unsigned StaggerCycles = 4,
  parameter int unsigned SoftRstCycles = 16,
  parameter bit          EarlyWakeEn   = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wake_i,
  input  logic [NrHarts-1:0]         soft_rst_req_i,
  input  logic [NrHarts*NrIrq-1:0]   irq_i,
  input  logic [NrHarts-1:0]         ipi_i,
  input  logic [NrHarts-1:0]         time_irq_i,
  input  logic [NrHarts-1:0]         debug_req_i,
  output logic [NrHarts-1:0]         hart_rst_o,
  output logic [NrHarts*NrIrq-1:0]   irq_o,
  output logic [NrHarts-1:0]         ipi_o,
  output logic [NrHarts-1:0]         time_irq_o,
  output logic [NrHarts-1:0]         debug_req_o,
  output logic [1:0]                 state_o,
  output logic                       all_released_o
);

  localparam int unsigned CntW   = $clog2(WakeCycles + 1);
  localparam int unsigned StgW   = (StaggerCycles > 1) ? $clog2(StaggerCycles) : 1;
  localparam int unsigned IdxW   = (NrHarts > 1) ? $clog2(NrHarts) : 1;
  localparam int unsigned SoftW  = $clog2(SoftRstCycles + 1);
  localparam int unsigned NrIrqW = NrHarts * NrIrq;
  localparam int unsigned AsyncW = NrIrqW + 3 * NrHarts;

  typedef enum logic [1:0] {
    StWait    = 2'd0,
    StStagger = 2'd1,
    StRun     = 2'd2
  } state_e;

  state_e                              state_q, state_d;
  logic [CntW-1:0]                     wait_cnt_q, wait_cnt_d;
  logic [StgW-1:0]                     stg_cnt_q, stg_cnt_d;
  logic [IdxW-1:0]                     idx_q, idx_d;
  logic [NrHarts-1:0]                  hart_rst_q, hart_rst_d;
  logic [NrHarts-1:0][SoftW-1:0]       soft_cnt_q, soft_cnt_d;
  logic [SyncStages-1:0][AsyncW-1:0]   sync_q, sync_d;
  logic [AsyncW-1:0]                   async_in, sync_last;

  assign async_in  = {debug_req_i, time_irq_i, ipi_i, irq_i};
  assign sync_last = sync_q[SyncStages-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StWait;
      wait_cnt_q <= '0;
      stg_cnt_q  <= '0;
      idx_q      <= '0;
      hart_rst_q <= '1;
      soft_cnt_q <= '0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stg_cnt_q  <= stg_cnt_d;
      idx_q      <= idx_d;
      hart_rst_q <= hart_rst_d;
      soft_cnt_q <= soft_cnt_d;
      sync_q     <= sync_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stg_cnt_d  = stg_cnt_q;
    idx_d      = idx_q;
    hart_rst_d = hart_rst_q;
    soft_cnt_d = soft_cnt_q;

    unique case (state_q)
      StWait: begin
        // Saturating counter: it parks at WakeCycles instead of wrapping.
        if (wait_cnt_q != CntW'(WakeCycles)) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if ((wait_cnt_q == CntW'(WakeCycles - 1)) || (EarlyWakeEn && wake_i)) begin
          hart_rst_d[0] = 1'b0;
          stg_cnt_d     = '0;
          idx_d         = IdxW'(1);
          state_d       = (NrHarts > 1) ? StStagger : StRun;
        end
      end
      StStagger: begin
        if (stg_cnt_q == StgW'(StaggerCycles - 1)) begin
          stg_cnt_d = '0;
          idx_d     = idx_q + 1'b1;
          for (int h = 1; h < NrHarts; h++) begin
            if (idx_q == IdxW'(h)) begin
              hart_rst_d[h] = 1'b0;
            end
          end
          if (idx_q == IdxW'(NrHarts - 1)) begin
            state_d = StRun;
          end
        end else begin
          stg_cnt_d = stg_cnt_q + 1'b1;
        end
      end
      StRun: begin
        // A request reloads the window; the reset drops as the counter leaves 1.
        for (int h = 0; h < NrHarts; h++) begin
          if (soft_rst_req_i[h]) begin
            soft_cnt_d[h] = SoftW'(SoftRstCycles);
            hart_rst_d[h] = 1'b1;
          end else if (soft_cnt_q[h] != '0) begin
            soft_cnt_d[h] = soft_cnt_q[h] - 1'b1;
            if (soft_cnt_q[h] == SoftW'(1)) begin
              hart_rst_d[h] = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = StWait;
      end
    endcase
  end

  always_comb begin
    sync_d[0] = async_in;
    for (int s = 1; s < SyncStages; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_comb begin
    irq_o       = '0;
    ipi_o       = '0;
    time_irq_o  = '0;
    debug_req_o = '0;
    for (int h = 0; h < NrHarts; h++) begin
      irq_o[h*NrIrq +: NrIrq] = sync_last[h*NrIrq +: NrIrq] & {NrIrq{~hart_rst_q[h]}};
      ipi_o[h]       = sync_last[NrIrqW + h] & ~hart_rst_q[h];
      time_irq_o[h]  = sync_last[NrIrqW + NrHarts + h] & ~hart_rst_q[h];
      debug_req_o[h] = sync_last[NrIrqW + 2*NrHarts + h] & ~hart_rst_q[h];
    end
  end

  assign hart_rst_o     = hart_rst_q;
  assign state_o        = state_q;
  assign all_released_o = ~|hart_rst_q;

endmodule

// File: tb/tb_cva6_wakeup_ctrl.sv
// Directed self-checking bench for cva6_wakeup_ctrl: release timeline, early wake,
// gating, soft reset, mid-operation reset and the single-hart corner case.
module tb_cva6_wakeup_ctrl;

  logic       clk;
  logic       rst;
  logic       wake;
  logic [2:0] soft_req;
  logic [5:0] irq_in;
  logic [2:0] ipi_in, tim_in, dbg_in;

  logic [2:0] a_hart_rst, a_ipi, a_tim, a_dbg;
  logic [5:0] a_irq;
  logic [1:0] a_state;
  logic       a_all;

  logic [2:0] b_hart_rst, b_ipi, b_tim, b_dbg;
  logic [5:0] b_irq;
  logic [1:0] b_state;
  logic       b_all;

  logic [1:0] s_irq_in, s_irq;
  logic       s_zero;
  logic       s_hart_rst, s_ipi, s_tim, s_dbg, s_all;
  logic [1:0] s_state;

  int vectors;
  int miscompares;
  int cyc;

  cva6_wakeup_ctrl #(
    .NrHarts(3), .NrIrq(2), .SyncStages(2), .WakeCycles(8),
    .StaggerCycles(4), .SoftRstCycles(5), .EarlyWakeEn(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wake_i(wake), .soft_rst_req_i(soft_req),
    .irq_i(irq_in), .ipi_i(ipi_in), .time_irq_i(tim_in), .debug_req_i(dbg_in),
    .hart_rst_o(a_hart_rst), .irq_o(a_irq), .ipi_o(a_ipi), .time_irq_o(a_tim),
    .debug_req_o(a_dbg), .state_o(a_state), .all_released_o(a_all)
  );

  cva6_wakeup_ctrl #(
    .NrHarts(3), .NrIrq(2), .SyncStages(2), .WakeCycles(8),
    .StaggerCycles(4), .SoftRstCycles(5), .EarlyWakeEn(1'b0)
  ) dut_ne (
    .clk_i(clk), .rst_i(rst), .wake_i(wake), .soft_rst_req_i(soft_req),
    .irq_i(irq_in), .ipi_i(ipi_in), .time_irq_i(tim_in), .debug_req_i(dbg_in),
    .hart_rst_o(b_hart_rst), .irq_o(b_irq), .ipi_o(b_ipi), .time_irq_o(b_tim),
    .debug_req_o(b_dbg), .state_o(b_state), .all_released_o(b_all)
  );

  cva6_wakeup_ctrl #(
    .NrHarts(1), .NrIrq(2), .SyncStages(2), .WakeCycles(1),
    .StaggerCycles(4), .SoftRstCycles(5), .EarlyWakeEn(1'b1)
  ) dut_single (
    .clk_i(clk), .rst_i(rst), .wake_i(s_zero), .soft_rst_req_i(s_zero),
    .irq_i(s_irq_in), .ipi_i(s_zero), .time_irq_i(s_zero), .debug_req_i(s_zero),
    .hart_rst_o(s_hart_rst), .irq_o(s_irq), .ipi_o(s_ipi), .time_irq_o(s_tim),
    .debug_req_o(s_dbg), .state_o(s_state), .all_released_o(s_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  // Advance to a given cycle number; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic waitCycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic releaseReset();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst         = 1'b1;
    wake        = 1'b0;
    soft_req    = '0;
    irq_in      = '0;
    ipi_in      = '0;
    tim_in      = '0;
    dbg_in      = '0;
    s_irq_in    = '0;
    s_zero      = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Timeline without wake; irq of hart 2 held from cycle 2.
    releaseReset();
    checkOutput("reset_hart_rst", 32'(a_hart_rst), 32'h7);
    checkOutput("reset_state", 32'(a_state), 32'd0);
    checkOutput("reset_all_rel", 32'(a_all), 32'd0);
    checkOutput("single_c0_hart_rst", 32'(s_hart_rst), 32'd1);
    waitCycle(1);
    checkOutput("single_c1_hart_rst", 32'(s_hart_rst), 32'd0);
    checkOutput("single_c1_state", 32'(s_state), 32'd2);
    checkOutput("single_c1_all_rel", 32'(s_all), 32'd1);
    waitCycle(2);
    irq_in[4] = 1'b1;
    waitCycle(7);
    checkOutput("c7_hart_rst", 32'(a_hart_rst), 32'h7);
    waitCycle(8);
    checkOutput("c8_hart_rst", 32'(a_hart_rst), 32'h6);
    checkOutput("c8_state", 32'(a_state), 32'd1);
    waitCycle(11);
    checkOutput("c11_hart_rst", 32'(a_hart_rst), 32'h6);
    waitCycle(12);
    checkOutput("c12_hart_rst", 32'(a_hart_rst), 32'h4);
    checkOutput("single_c12_state", 32'(s_state), 32'd2);
    waitCycle(15);
    checkOutput("c15_hart_rst", 32'(a_hart_rst), 32'h4);
    checkOutput("c15_irq_gated", 32'(a_irq), 32'h00);
    checkOutput("c15_all_rel", 32'(a_all), 32'd0);
    waitCycle(16);
    checkOutput("c16_hart_rst", 32'(a_hart_rst), 32'h0);
    checkOutput("c16_state", 32'(a_state), 32'd2);
    checkOutput("c16_all_rel", 32'(a_all), 32'd1);
    checkOutput("c16_irq", 32'(a_irq), 32'h10);
    checkOutput("ne_c16_hart_rst", 32'(b_hart_rst), 32'h0);

    // Synchronizer latency on ipi and debug.
    waitCycle(17);
    ipi_in[0] = 1'b1;
    dbg_in[1] = 1'b1;
    waitCycle(18);
    checkOutput("c18_ipi", 32'(a_ipi), 32'h0);
    waitCycle(19);
    checkOutput("c19_ipi", 32'(a_ipi), 32'h1);
    checkOutput("c19_dbg", 32'(a_dbg), 32'h2);
    ipi_in[0] = 1'b0;
    waitCycle(20);
    checkOutput("c20_ipi", 32'(a_ipi), 32'h1);
    checkOutput("c20_hart_rst", 32'(a_hart_rst), 32'h0);

    // Soft reset of hart 1 at T=20, re-requested at T+3.
    soft_req = 3'b010;
    waitCycle(21);
    soft_req = 3'b000;
    checkOutput("c21_ipi", 32'(a_ipi), 32'h0);
    checkOutput("soft_t1_hart_rst", 32'(a_hart_rst), 32'h2);
    checkOutput("soft_t1_all_rel", 32'(a_all), 32'd0);
    checkOutput("soft_t1_dbg", 32'(a_dbg), 32'h0);
    waitCycle(23);
    checkOutput("soft_t3_hart_rst", 32'(a_hart_rst), 32'h2);
    soft_req = 3'b010;
    waitCycle(24);
    soft_req = 3'b000;
    waitCycle(26);
    checkOutput("soft_t6_hart_rst", 32'(a_hart_rst), 32'h2);
    checkOutput("soft_t6_dbg", 32'(a_dbg), 32'h0);
    waitCycle(28);
    checkOutput("soft_t8_hart_rst", 32'(a_hart_rst), 32'h2);
    checkOutput("ne_soft_t8_hart_rst", 32'(b_hart_rst), 32'h2);
    waitCycle(29);
    checkOutput("soft_t9_hart_rst", 32'(a_hart_rst), 32'h0);
    checkOutput("soft_t9_all_rel", 32'(a_all), 32'd1);
    checkOutput("soft_t9_dbg", 32'(a_dbg), 32'h2);

    // Early wake at cycle 3; soft request at cycle 5 must be ignored.
    rst = 1'b1;
    waitCycle(31);
    releaseReset();
    checkOutput("ew_c0_state", 32'(a_state), 32'd0);
    waitCycle(3);
    wake = 1'b1;
    checkOutput("ew_c3_hart_rst", 32'(a_hart_rst), 32'h7);
    waitCycle(4);
    wake = 1'b0;
    checkOutput("ew_c4_hart_rst", 32'(a_hart_rst), 32'h6);
    checkOutput("ne_c4_hart_rst", 32'(b_hart_rst), 32'h7);
    waitCycle(5);
    soft_req = 3'b111;
    waitCycle(6);
    soft_req = 3'b000;
    checkOutput("ew_c6_hart_rst", 32'(a_hart_rst), 32'h6);
    checkOutput("ne_c6_hart_rst", 32'(b_hart_rst), 32'h7);
    checkOutput("ne_c6_state", 32'(b_state), 32'd0);
    waitCycle(7);
    checkOutput("ew_c7_hart_rst", 32'(a_hart_rst), 32'h6);
    waitCycle(8);
    checkOutput("ew_c8_hart_rst", 32'(a_hart_rst), 32'h4);
    checkOutput("ne_c8_hart_rst", 32'(b_hart_rst), 32'h6);
    waitCycle(12);
    checkOutput("ew_c12_hart_rst", 32'(a_hart_rst), 32'h0);
    checkOutput("ew_c12_state", 32'(a_state), 32'd2);
    checkOutput("ew_c12_all_rel", 32'(a_all), 32'd1);
    checkOutput("ne_c12_hart_rst", 32'(b_hart_rst), 32'h4);
    waitCycle(13);
    checkOutput("ne_c13_state", 32'(b_state), 32'd1);

    // Reset mid-operation in cycle 13, then the timeline repeats.
    rst = 1'b1;
    waitCycle(14);
    checkOutput("mid_hart_rst", 32'(b_hart_rst), 32'h7);
    checkOutput("mid_state", 32'(b_state), 32'd0);
    checkOutput("mid_ew_hart_rst", 32'(a_hart_rst), 32'h7);
    checkOutput("mid_ew_state", 32'(a_state), 32'd0);
    checkOutput("mid_irq", 32'(a_irq), 32'h0);
    checkOutput("mid_dbg", 32'(a_dbg), 32'h0);
    checkOutput("mid_all_rel", 32'(a_all), 32'd0);
    releaseReset();
    waitCycle(7);
    checkOutput("re_c7_hart_rst", 32'(b_hart_rst), 32'h7);
    waitCycle(8);
    checkOutput("re_c8_hart_rst", 32'(b_hart_rst), 32'h6);
    waitCycle(12);
    checkOutput("re_c12_hart_rst", 32'(b_hart_rst), 32'h4);
    waitCycle(15);
    checkOutput("re_c15_irq", 32'(b_irq), 32'h00);
    waitCycle(16);
    checkOutput("re_c16_hart_rst", 32'(b_hart_rst), 32'h0);
    checkOutput("re_c16_state", 32'(b_state), 32'd2);
    checkOutput("re_c16_irq", 32'(b_irq), 32'h10);
    checkOutput("re_c16_all_rel", 32'(b_all), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cva6_wakeup_ctrl.md
# cva6_wakeup_ctrl

Multi-hart reset-release and interrupt-conditioning controller that sits between the tile-level reset/interrupt sources and N CVA6 cores. It is a parametrised successor to the single-hart wake-up counter plus synchronizer scheme. It adds a configurable SRAM-init wait, early wake on a synchronous event, and staggered per-hart reset release. It also adds per-hart software reset and gating of interrupts toward harts held in reset.

## Interface
Parameters:
- NrHarts, 2, number of harts served (≥1)
- NrIrq, 2, level-sensitive irq lines per hart (mip/sip)
- SyncStages, 2, flops per async synchronizer (≥2)
- WakeCycles, 32768, cycles held after reset before first release (≥1)
- StaggerCycles, 4, cycles between consecutive hart releases (≥1)
- SoftRstCycles, 16, length of a software-requested hart reset (≥1)
- EarlyWakeEn, 1, wake_i may end the wait early

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- wake_i  in  1  synchronous wake pulse, e.g. L15 interrupt return valid
- soft_rst_req_i  in  NrHarts  per-hart soft reset request pulse, synchronous
- irq_i  in  NrHarts*NrIrq  async irq lines, hart h at [h*NrIrq +: NrIrq]
- ipi_i  in  NrHarts  async inter-processor interrupt
- time_irq_i  in  NrHarts  async timer interrupt
- debug_req_i  in  NrHarts  async debug request
- hart_rst_o  out  NrHarts  active-high reset to each hart, registered
- irq_o, ipi_o, time_irq_o, debug_req_o  out  same widths as inputs  synchronized, gated
- state_o  out  2  FSM state: WAIT=0, STAGGER=1, RUN=2
- all_released_o  out  1  high when every hart_rst_o bit is 0

## Operation
- Reset values: state WAIT; wait counter 0; hart_rst_o all ones; all sync flops 0; every irq/ipi/time/debug output 0; all_released_o 0; soft counters 0.
- WAIT:
  - The counter increments every cycle.
  - Exit when the counter equals WakeCycles-1, or when EarlyWakeEn and wake_i are both high.
  - On exit, hart_rst_o[0] is cleared.
  - Next state is STAGGER if NrHarts>1, else RUN.
  - Counter width is $clog2(WakeCycles+1). It never wraps.
- STAGGER:
  - A stagger counter and a hart index (starting at 1) run.
  - Every StaggerCycles cycles, hart_rst_o[index] is cleared and the index increments.
  - Releasing the last hart moves the FSM to RUN in the same edge.
  - wake_i is ignored here.
- RUN:
  - soft_rst_req_i[h] sets hart_rst_o[h] and loads soft counter h with SoftRstCycles.
  - The counter decrements each cycle. hart_rst_o[h] clears when it reaches 0.
  - A new request during an active soft reset reloads the counter (restart, not accumulate).
  - Harts are independent; simultaneous requests to several harts are all honoured.
  - Soft requests outside RUN are ignored. wake_i is ignored in RUN.
- Synchronizers: each async bit passes through a SyncStages-deep flop chain.
- Gating: output bit = last sync flop AND NOT hart_rst_o[h] of the owning hart. This is combinational from registers.
- all_released_o = ~|hart_rst_o, combinational from registers.
- Reset mid-operation: rst_i high in any state returns everything to reset values at the next edge. Soft counters and the stagger index are discarded.

## Timing
- Cycle 0 is the first cycle with rst_i sampled low.
- Without early wake, hart k's reset deasserts in cycle WakeCycles + k*StaggerCycles.
- With early wake, wake_i sampled in cycle c (WAIT) deasserts hart k's reset in cycle c+1+k*StaggerCycles.
- state_o becomes RUN and all_released_o rises in the same cycle the last hart is released.
- Async input latency: a change stable before edge e is visible at the output after edge e+SyncStages-1, provided the hart is out of reset.
- A soft request sampled in cycle t sets hart_rst_o[h]=1 for cycles t+1 .. t+SoftRstCycles, and the hart's gated outputs are 0 during that window.

## Test plan
Parameters for scenarios 1-5: NrHarts=3, WakeCycles=8, StaggerCycles=4, SoftRstCycles=5, SyncStages=2, EarlyWakeEn=1.

1. Release rst_i with no wake_i.
   - hart_rst_o=3'b111 in cycles 0-7, 3'b110 from cycle 8, 3'b100 from 12, 3'b000 from 16.
   - state_o=2 and all_released_o=1 from cycle 16.
2. Early wake.
   - wake_i pulse in cycle 3 gives releases at cycles 4, 8, 12.
   - With EarlyWakeEn=0 the same stimulus reproduces scenario 1.
3. Interrupt gating.
   - irq_i[hart2] held high from cycle 2: irq_o[hart2] is 0 until cycle 16, then 1.
   - ipi_i[0] toggled in RUN appears on ipi_o[0] 2 cycles later.
4. Soft reset.
   - In RUN, soft_rst_req_i=3'b010 in cycle T gives hart_rst_o[1]=1 in cycles T+1..T+5, all_released_o=0 there, and debug_req_o[1] forced 0.
   - A re-request at T+3 extends the window to T+8.
   - A request in cycle 5 (WAIT) has no effect.
5. Reset mid-operation.
   - rst_i high in cycle 13 gives hart_rst_o=3'b111 and state_o=0 from cycle 14.
   - Outputs are 0, and the release timeline repeats from the new reset release.
6. NrHarts=1, WakeCycles=1.
   - hart_rst_o=0 and state_o=RUN from cycle 1; STAGGER is never entered.
